// File: rtl/dbg_link_pkg.sv
// Shared constants for the pipeline debug link (serializer and deserializer).
// Frame layout: SYNC, payload bytes (IF_ID first, LSB first), XOR checksum.
package dbg_link_pkg;

   localparam int NB_DATA   = 8;
   localparam int NB_IF_ID  = 64;
   localparam int NB_ID_EX  = 168;
   localparam int NB_EX_MEM = 88;
   localparam int NB_MEM_WB = 80;

   localparam int IF_ID_BYTES  = NB_IF_ID  / NB_DATA;
   localparam int ID_EX_BYTES  = NB_ID_EX  / NB_DATA;
   localparam int EX_MEM_BYTES = NB_EX_MEM / NB_DATA;
   localparam int MEM_WB_BYTES = NB_MEM_WB / NB_DATA;

   localparam int N_PAY    = IF_ID_BYTES + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;
   localparam int NB_TOTAL = N_PAY * NB_DATA;

   localparam int OFF_IF_ID  = 0;
   localparam int OFF_ID_EX  = OFF_IF_ID  + NB_IF_ID;
   localparam int OFF_EX_MEM = OFF_ID_EX  + NB_ID_EX;
   localparam int OFF_MEM_WB = OFF_EX_MEM + NB_EX_MEM;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } dbg_state_e;

endpackage

// File: rtl/dbg_gap_timer.sv
// Loadable down-counter; flags expiry when it sits at zero while enabled.
module dbg_gap_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load)
         cnt_d = RELOAD;
      else if (i_en && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign o_expired = i_en && (cnt_q == '0);

endmodule

// File: rtl/dbg_frame_deserializer.sv
// Reassembles debug-dump frames into pipeline latch snapshots.
// Shadow and output registers are separate so outputs hold during reception.
module dbg_frame_deserializer #(
   parameter int NB_DATA   = 8,
   parameter int NB_IF_ID  = 64,
   parameter int NB_ID_EX  = 168,
   parameter int NB_EX_MEM = 88,
   parameter int NB_MEM_WB = 80,
   parameter logic [NB_DATA-1:0] SYNC_BYTE = dbg_link_pkg::SYNC_BYTE,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rx_done,
   input  logic [NB_DATA-1:0]   i_rx_data,
   output logic [NB_IF_ID-1:0]  o_IF_ID,
   output logic [NB_ID_EX-1:0]  o_ID_EX,
   output logic [NB_EX_MEM-1:0] o_EX_MEM,
   output logic [NB_MEM_WB-1:0] o_MEM_WB,
   output logic                 o_frame_valid,
   output logic                 o_frame_err,
   output logic                 o_timeout,
   output logic                 o_busy,
   output logic [15:0]          o_frame_count
);

   import dbg_link_pkg::*;

   localparam int TOT_BITS  = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
   localparam int PAY_BYTES = TOT_BITS / NB_DATA;
   localparam int CW        = $clog2(PAY_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(PAY_BYTES - 1);

   dbg_state_e state_q, state_d;

   logic [CW-1:0]       idx_q, idx_d;
   logic [NB_DATA-1:0]  acc_q, acc_d;
   logic [TOT_BITS-1:0] shadow_q, shadow_d;
   logic [TOT_BITS-1:0] out_q, out_d;
   logic [15:0]         fcnt_q, fcnt_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic                tmo_q, tmo_d;
   logic                tmr_load, tmr_en, tmr_exp;

   assign tmr_en = (state_q != ST_IDLE);

   dbg_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap_timer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_load   (tmr_load),
      .i_en     (tmr_en),
      .o_expired(tmr_exp)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      fcnt_d   = fcnt_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      tmo_d    = 1'b0;
      tmr_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
               state_d  = ST_PAYLOAD;
               idx_d    = '0;
               acc_d    = '0;
               tmr_load = 1'b1;
            end
         end
         ST_PAYLOAD: begin
            // A byte arriving on the expiry cycle still counts
            if (i_rx_done) begin
               shadow_d[idx_q*NB_DATA +: NB_DATA] = i_rx_data;
               acc_d    = acc_q ^ i_rx_data;
               idx_d    = idx_q + 1'b1;
               tmr_load = 1'b1;
               if (idx_q == LAST)
                  state_d = ST_CHECK;
            end else if (tmr_exp) begin
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (i_rx_done) begin
               state_d  = ST_IDLE;
               tmr_load = 1'b1;
               if (i_rx_data == acc_q) begin
                  out_d   = shadow_q;
                  fcnt_d  = fcnt_q + 16'd1;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (tmr_exp) begin
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         shadow_q <= '0;
         out_q    <= '0;
         fcnt_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         fcnt_q   <= fcnt_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign o_IF_ID       = out_q[0 +: NB_IF_ID];
   assign o_ID_EX       = out_q[NB_IF_ID +: NB_ID_EX];
   assign o_EX_MEM      = out_q[NB_IF_ID+NB_ID_EX +: NB_EX_MEM];
   assign o_MEM_WB      = out_q[NB_IF_ID+NB_ID_EX+NB_EX_MEM +: NB_MEM_WB];
   assign o_frame_valid = valid_q;
   assign o_frame_err   = err_q;
   assign o_timeout     = tmo_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_frame_count = fcnt_q;

endmodule

// File: tb/tb_dbg_frame_deserializer.sv
// Scoreboard bench: frame generator queues expected outcomes, a monitor
// pops and compares on every valid/err/timeout pulse.
module tb_dbg_frame_deserializer;

   localparam int NP  = 50;
   localparam int NT  = 400;
   localparam int TMO = 50;

   typedef struct {
      int          kind;
      logic [NT-1:0] p;
      logic [15:0] cnt;
      int          lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx_done;
   logic [7:0]    rx_data;
   logic [63:0]   o_if_id;
   logic [167:0]  o_id_ex;
   logic [87:0]   o_ex_mem;
   logic [79:0]   o_mem_wb;
   logic          o_valid, o_err, o_tmo, o_busy;
   logic [15:0]   o_cnt;

   exp_t          sbq[$];
   logic [NT-1:0] mdl_p, gen_p;
   logic [15:0]   mdl_cnt, gen_cnt;
   int            checks = 0;
   int            passes = 0;
   int            cyc = 0;
   int            last_rx = 0;

   always #5 clk = ~clk;

   dbg_frame_deserializer #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_rx_done    (rx_done),
      .i_rx_data    (rx_data),
      .o_IF_ID      (o_if_id),
      .o_ID_EX      (o_id_ex),
      .o_EX_MEM     (o_ex_mem),
      .o_MEM_WB     (o_mem_wb),
      .o_frame_valid(o_valid),
      .o_frame_err  (o_err),
      .o_timeout    (o_tmo),
      .o_busy       (o_busy),
      .o_frame_count(o_cnt)
   );

   function automatic logic [NT-1:0] dut_p();
      return {o_mem_wb, o_ex_mem, o_id_ex, o_if_id};
   endfunction

   task automatic chk(input string nm, input logic [NT-1:0] act,
                      input logic [NT-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: one pulse -> one scoreboard entry; otherwise outputs hold.
   initial begin
      int   k;
      int   n;
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         if (rx_done) last_rx = cyc;
         #1;
         n = int'(o_valid) + int'(o_err) + int'(o_tmo);
         if (n > 1) chk("pulse_exclusive", NT'(n), NT'(1));
         if (n != 0) begin
            k = o_valid ? 0 : (o_err ? 1 : 2);
            if (sbq.size() == 0) begin
               chk("unexpected_pulse_kind", NT'(k), NT'(99));
            end else begin
               e = sbq.pop_front();
               chk("event_kind", NT'(k), NT'(e.kind));
               chk("event_latency", NT'(cyc - last_rx), NT'(e.lat));
               chk("event_fields", dut_p(), e.p);
               chk("event_count", NT'(o_cnt), NT'(e.cnt));
               chk("event_busy", NT'(o_busy), NT'(0));
               if (e.kind == 0) begin
                  mdl_p   = e.p;
                  mdl_cnt = e.cnt;
               end
            end
         end else begin
            chk("hold_fields", dut_p(), mdl_p);
            chk("hold_count", NT'(o_cnt), NT'(mdl_cnt));
         end
      end
   end

   // Called on a negedge; returns on the following negedge.
   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = $urandom_range(0, 255);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] pl[NP], input logic [7:0] ck,
                             input int maxgap);
      logic [7:0]    x;
      logic [NT-1:0] p;
      exp_t          e;
      x = 8'h00;
      p = '0;
      for (int k = 0; k < NP; k++) begin
         x ^= pl[k];
         p[8*k +: 8] = pl[k];
      end
      send_byte(8'hA5);
      idle($urandom_range(0, maxgap));
      for (int k = 0; k < NP; k++) begin
         send_byte(pl[k]);
         idle($urandom_range(0, maxgap));
      end
      if (ck == x) begin
         gen_cnt = gen_cnt + 16'd1;
         gen_p   = p;
         e.kind  = 0;
      end else begin
         e.kind = 1;
      end
      e.p   = gen_p;
      e.cnt = gen_cnt;
      e.lat = 0;
      sbq.push_back(e);
      send_byte(ck);
   endtask

   task automatic partial_timeout(input int nb);
      exp_t e;
      send_byte(8'hA5);
      for (int k = 0; k < nb; k++) send_byte($urandom_range(0, 255));
      e.kind = 2;
      e.p    = gen_p;
      e.cnt  = gen_cnt;
      e.lat  = TMO;
      sbq.push_back(e);
      idle(TMO + 4);
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] pl[NP]);
      logic [7:0] x = 8'h00;
      for (int k = 0; k < NP; k++) x ^= pl[k];
      return x;
   endfunction

   initial begin
      logic [7:0] pl[NP];
      logic [7:0] b;
      int         w;
      rst_n   = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      mdl_p   = '0;
      mdl_cnt = '0;
      gen_p   = '0;
      gen_cnt = '0;
      idle(3);
      chk("reset_fields", dut_p(), '0);
      chk("reset_pulses", NT'({o_valid, o_err, o_tmo, o_busy}), '0);
      chk("reset_count", NT'(o_cnt), '0);
      rst_n = 1'b1;
      idle(2);

      for (int k = 0; k < NP; k++) pl[k] = 8'(k + 1);
      send_frame(pl, 8'h33, 2);
      idle(2);
      chk("good_if_id", NT'(o_if_id), NT'(64'h0807060504030201));
      chk("good_count", NT'(o_cnt), NT'(1));

      for (int k = 0; k < NP; k++) pl[k] = $urandom_range(0, 255);
      send_frame(pl, xsum(pl) ^ 8'h01, 1);
      idle(2);
      chk("bad_keeps_if_id", NT'(o_if_id), NT'(64'h0807060504030201));

      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      idle(3);
      send_frame(pl, xsum(pl), 1);
      idle(2);

      partial_timeout(10);
      chk("timeout_busy_low", NT'(o_busy), NT'(0));
      send_frame(pl, xsum(pl), 0);
      idle(2);

      for (int k = 0; k < NP; k++) pl[k] = 8'hA5;
      send_frame(pl, 8'h00, 1);
      idle(2);
      chk("sync_payload_mem_wb", NT'(o_mem_wb), NT'({10{8'hA5}}));

      for (int k = 0; k < NP; k++) pl[k] = $urandom_range(0, 255);
      send_frame(pl, xsum(pl), 0);
      send_frame(pl, xsum(pl), 0);
      idle(2);
      chk("back_to_back_count", NT'(o_cnt), NT'(gen_cnt));

      for (int k = 0; k < NP; k++) pl[k] = 8'(k + 1);
      send_byte(8'hA5);
      for (int k = 0; k < 20; k++) send_byte(pl[k]);
      rst_n   = 1'b0;
      mdl_p   = '0;
      mdl_cnt = '0;
      gen_p   = '0;
      gen_cnt = '0;
      #1;
      chk("midreset_fields", dut_p(), '0);
      chk("midreset_flags", NT'({o_valid, o_err, o_tmo, o_busy}), '0);
      chk("midreset_count", NT'(o_cnt), '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 20; k < NP; k++) send_byte(pl[k]);
      send_byte(8'h33);
      idle(3);
      chk("midreset_ignored_busy", NT'(o_busy), NT'(0));
      send_frame(pl, 8'h33, 1);
      idle(2);

      for (int f = 0; f < 25; f++) begin
         w = $urandom_range(0, 3);
         for (int k = 0; k < w; k++) begin
            b = $urandom_range(0, 255);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
            idle($urandom_range(0, 2));
         end
         if ($urandom_range(0, 7) == 0) begin
            partial_timeout($urandom_range(0, NP));
         end else begin
            for (int k = 0; k < NP; k++) pl[k] = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0)
               send_frame(pl, xsum(pl) ^ 8'($urandom_range(1, 255)), 3);
            else
               send_frame(pl, xsum(pl), 3);
         end
      end

      for (int t = 0; t < 200 && sbq.size() != 0; t++) idle(1);
      idle(3);
      chk("scoreboard_drained", NT'(sbq.size()), '0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
